// File: rtl/chu_pwm_mc_core_if.sv
// FPro MMIO slot bus seen by the multi-channel PWM core.
interface chu_pwm_mc_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_pwm_mc_core.sv
// Multi-channel PWM slot: shared prescaler, edge/center counter, double-buffered duty.
// Define PWM_WRAP_IRQ_EN to get the sticky wrap flag, ctrl bit2 irq enable and irq output.
module chu_pwm_mc_lane #(
  parameter int R = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         load,
  input  logic         en,
  input  logic [31:0]  wr_data,
  input  logic [R-1:0] cnt,
  output logic [R:0]   shadow,
  output logic         pwm
);
  localparam logic [31:0] FULL = 32'd1 << R;

  logic [R:0] duty_in, shadow_d, active;

  // Anything above full scale is stored as full scale (always high).
  assign duty_in  = (wr_data > FULL) ? FULL[R:0] : wr_data[R:0];
  assign shadow_d = wr ? duty_in : shadow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      shadow <= shadow_d;
      if (load) active <= shadow_d;
      pwm <= en & ({1'b0, cnt} < active);
    end
  end
endmodule

module chu_pwm_mc_core #(
  parameter int W = 8,
  parameter int R = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  chu_pwm_mc_core_if.slave       bus,
  output logic [W-1:0]           pwm,
  output logic                   irq
);
  localparam logic [R-1:0] CMAX = '1;
  localparam logic [R-1:0] ONE  = R'(1);

  typedef struct packed {
    logic irq_en;
    logic mode;
    logic en;
  } ctrl_t;

  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  logic [31:0]       dvsr, q;
  ctrl_t             ctrl, ctrl_d;
  logic              mode_act;
  logic [R-1:0]      cnt, cnt_nxt;
  dir_t              dir, dir_nxt;
  logic              tick, boundary, load, status;
  logic              wr_en, wr_dvsr, wr_ctrl;
  logic [W-1:0]      lane_wr;
  logic [W-1:0][R:0] shadow;
  logic              unused;

  assign wr_en   = bus.cs & bus.write;
  assign wr_dvsr = wr_en & (bus.addr == 5'd0);
  assign wr_ctrl = wr_en & (bus.addr == 5'd1);
  assign unused  = bus.read;

  always_comb begin
    ctrl_d = ctrl;
    if (wr_ctrl) ctrl_d = ctrl_t'(bus.wr_data[2:0]);
`ifndef PWM_WRAP_IRQ_EN
    ctrl_d.irq_en = 1'b0;
`endif
  end

  assign tick = ctrl.en & (q == dvsr);

  // Counter direction FSM; mode_act only changes on a boundary so a period never mixes modes.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!ctrl.en) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      if (!mode_act) begin
        cnt_nxt  = cnt + ONE;
        dir_nxt  = DIR_UP;
        boundary = (cnt == CMAX);
      end else begin
        case (dir)
          DIR_UP: begin
            if (cnt == CMAX) begin
              cnt_nxt = cnt - ONE;
              dir_nxt = DIR_DN;
            end else begin
              cnt_nxt = cnt + ONE;
            end
          end
          DIR_DN: begin
            cnt_nxt = cnt - ONE;
            if (cnt == ONE) begin
              boundary = 1'b1;
              dir_nxt  = DIR_UP;
            end
          end
          default: dir_nxt = DIR_UP;
        endcase
      end
    end
  end

  // While disabled, shadow writes fall straight through to the active duty.
  assign load = boundary | ~ctrl.en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dvsr     <= '0;
      ctrl     <= '0;
      q        <= '0;
      cnt      <= '0;
      dir      <= DIR_UP;
      mode_act <= 1'b0;
    end else begin
      if (wr_dvsr) dvsr <= bus.wr_data;
      ctrl <= ctrl_d;
      q    <= (!ctrl.en || wr_dvsr || tick) ? '0 : q + 32'd1;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      if (!ctrl.en || boundary) mode_act <= ctrl_d.mode;
    end
  end

`ifdef PWM_WRAP_IRQ_EN
  logic wr_stat;
  assign wr_stat = wr_en & (bus.addr == 5'd2);

  always_ff @(posedge clk) begin
    if (!reset_n)      status <= 1'b0;
    else if (boundary) status <= 1'b1;
    else if (wr_stat)  status <= 1'b0;
  end

  assign irq = status & ctrl.irq_en;
`else
  assign status = 1'b0;
  assign irq    = 1'b0;
`endif

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign lane_wr[i] = wr_en & (bus.addr == 5'(16 + i));
    chu_pwm_mc_lane #(.R(R)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (lane_wr[i]),
      .load    (load),
      .en      (ctrl.en),
      .wr_data (bus.wr_data),
      .cnt     (cnt),
      .shadow  (shadow[i]),
      .pwm     (pwm[i])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      5'd0:    bus.rd_data = dvsr;
      5'd1:    bus.rd_data = {29'd0, ctrl};
      5'd2:    bus.rd_data = {31'd0, status};
      default: begin
        for (int i = 0; i < W; i++)
          if (bus.addr == 5'(16 + i)) bus.rd_data = 32'(shadow[i]);
      end
    endcase
  end
endmodule
